// File: rtl/lpc_reg_pkg.sv
// Shared types and constants for the LPC register bank and its unlock FSM.
// Optional build macro used by this slice: LPC_REG_RELOCK_TIMEOUT_EN.
package lpc_reg_pkg;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        KEY1     = 2'd1,
        UNLOCKED = 2'd2
    } lock_state_t;

    localparam logic [7:0] KEY_CODE1 = 8'h55;
    localparam logic [7:0] KEY_CODE2 = 8'hAA;

    localparam logic [7:0] DEF_KEY_ADDR  = 8'h1C;
    localparam logic [7:0] DEF_STAT_ADDR = 8'h1D;
    localparam logic [7:0] DEF_IEN_ADDR  = 8'h1E;

endpackage

// File: rtl/lpc_reg_unlock_fsm.sv
// Write-protect unlock FSM (0x55, 0xAA key sequence) with an optional idle relock
// timer enabled by LPC_REG_RELOCK_TIMEOUT_EN.
module lpc_reg_unlock_fsm
    import lpc_reg_pkg::*;
#(
    parameter int RELOCK_CYC = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        key_wr_i,
    input  logic [7:0]  key_data_i,
    input  logic        other_wr_i,
`ifdef LPC_REG_RELOCK_TIMEOUT_EN
    input  logic        acc_wr_i,
`endif
    output lock_state_t state_o
);

    lock_state_t state_q, state_d;

`ifdef LPC_REG_RELOCK_TIMEOUT_EN
    localparam int CNT_W = $clog2(RELOCK_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts only while resting in UNLOCKED; any write or key activity restarts it.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q != UNLOCKED || state_d != UNLOCKED || acc_wr_i || key_wr_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOCKED: begin
                if (key_wr_i) begin
                    state_d = (key_data_i == KEY_CODE1) ? KEY1 : LOCKED;
                end
            end
            KEY1: begin
                if (key_wr_i) begin
                    state_d = (key_data_i == KEY_CODE2) ? UNLOCKED : LOCKED;
                end else if (other_wr_i) begin
                    state_d = LOCKED;
                end
            end
            UNLOCKED: begin
                if (key_wr_i) begin
                    state_d = LOCKED;
`ifdef LPC_REG_RELOCK_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(RELOCK_CYC)) begin
                    state_d = LOCKED;
`endif
                end
            end
            default: state_d = LOCKED;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= LOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/lpc_reg_bank.sv
// Parametrised LPC register bank: masked/protected writes, key unlock, W1C status,
// interrupt and registered read port. Optional macro: LPC_REG_RELOCK_TIMEOUT_EN.
module lpc_reg_bank
    import lpc_reg_pkg::*;
#(
    parameter int                       NUM_REGS   = 32,
    parameter int                       AW         = 8,
    parameter int                       DW         = 8,
    parameter logic [NUM_REGS*DW-1:0]   RESET_VAL  = '0,
    parameter logic [NUM_REGS*DW-1:0]   WR_MASK    = '1,
    parameter logic [NUM_REGS-1:0]      PROT_MASK  = '0,
    parameter logic [AW-1:0]            KEY_ADDR   = AW'(DEF_KEY_ADDR),
    parameter logic [AW-1:0]            STAT_ADDR  = AW'(DEF_STAT_ADDR),
    parameter logic [AW-1:0]            IEN_ADDR   = AW'(DEF_IEN_ADDR),
    parameter int                       EVT_W      = 8,
    parameter int                       RELOCK_CYC = 1024
) (
    input  logic                     LpcClock,
    input  logic                     PciReset,
    input  logic [AW-1:0]            Addr,
    input  logic                     Wr,
    input  logic [DW-1:0]            DataWr,
    input  logic                     Rd,
    output logic [DW-1:0]            RdData,
    output logic                     RdValid,
    input  logic [EVT_W-1:0]         HwEvent,
    output logic [NUM_REGS*DW-1:0]   RegFlat,
    output logic [NUM_REGS-1:0]      WrStrobe,
    output logic                     Unlocked,
    output logic                     Irq
);

    localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int IEN_IDX = int'(IEN_ADDR);

    logic [DW-1:0]       regs_q [NUM_REGS];
    logic [DW-1:0]       regs_d [NUM_REGS];
    logic [EVT_W-1:0]    stat_q, stat_d;
    logic [DW-1:0]       rd_data_q, rd_data_d;
    logic                rd_valid_q;
    logic [NUM_REGS-1:0] wr_strobe_q, wr_strobe_d;
    logic                irq_q;

    lock_state_t         lock_state;
    logic                in_range;
    logic [IDX_W-1:0]    idx;
    logic                key_hit, stat_hit, gen_hit, gen_ok, acc_wr;
    logic [DW-1:0]       key_view, stat_view, wmask;

    assign in_range = (32'(Addr) < NUM_REGS);
    assign idx      = Addr[IDX_W-1:0];
    assign key_hit  = Wr && in_range && (Addr == KEY_ADDR);
    assign stat_hit = Wr && in_range && (Addr == STAT_ADDR);
    assign gen_hit  = Wr && in_range && !key_hit && !stat_hit;
    // Protection is judged against the state before this edge's key write.
    assign gen_ok   = gen_hit && (!PROT_MASK[idx] || lock_state == UNLOCKED);
    assign acc_wr   = gen_ok || key_hit || stat_hit;
    assign wmask    = WR_MASK[32'(idx)*DW +: DW];

    always_comb begin
        key_view      = '0;
        key_view[1:0] = lock_state;
    end

    assign stat_view = DW'(stat_q);

    lpc_reg_unlock_fsm #(
        .RELOCK_CYC (RELOCK_CYC)
    ) u_unlock_fsm (
        .clk_i      (LpcClock),
        .rst_i      (PciReset),
        .key_wr_i   (key_hit),
        .key_data_i (DataWr[7:0]),
        .other_wr_i (Wr && !key_hit),
`ifdef LPC_REG_RELOCK_TIMEOUT_EN
        .acc_wr_i   (acc_wr),
`endif
        .state_o    (lock_state)
    );

    always_comb begin
        regs_d = regs_q;
        if (gen_ok) begin
            regs_d[idx] = (wmask & DataWr) | (~wmask & regs_q[idx]);
        end
    end

    // Hardware set is OR-ed in after the clear so it wins on the same bit.
    assign stat_d = (stat_q & ~(stat_hit ? DataWr[EVT_W-1:0] : '0)) | HwEvent;

    always_comb begin
        wr_strobe_d = '0;
        if (acc_wr) begin
            wr_strobe_d[idx] = 1'b1;
        end
    end

    always_comb begin
        rd_data_d = '0;
        if (in_range) begin
            if (Addr == KEY_ADDR) begin
                rd_data_d = key_view;
            end else if (Addr == STAT_ADDR) begin
                rd_data_d = stat_view;
            end else begin
                rd_data_d = regs_q[idx];
            end
        end
    end

    always_ff @(posedge LpcClock) begin
        if (PciReset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL[i*DW +: DW];
            end
            stat_q      <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            wr_strobe_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            stat_q      <= stat_d;
            rd_data_q   <= Rd ? rd_data_d : rd_data_q;
            rd_valid_q  <= Rd;
            wr_strobe_q <= wr_strobe_d;
            irq_q       <= |(stat_q & regs_q[IEN_IDX][EVT_W-1:0]);
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        if (g == int'(KEY_ADDR)) begin : g_key
            assign RegFlat[g*DW +: DW] = key_view;
        end else if (g == int'(STAT_ADDR)) begin : g_stat
            assign RegFlat[g*DW +: DW] = stat_view;
        end else begin : g_reg
            assign RegFlat[g*DW +: DW] = regs_q[g];
        end
    end

    assign RdData   = rd_data_q;
    assign RdValid  = rd_valid_q;
    assign WrStrobe = wr_strobe_q;
    assign Unlocked = (lock_state == UNLOCKED);
    assign Irq      = irq_q;

endmodule

// File: tb/tb_lpc_reg_bank.sv
// Directed bench for lpc_reg_bank; relock-timeout checks follow LPC_REG_RELOCK_TIMEOUT_EN.
module tb_lpc_reg_bank;

    localparam int NR = 32;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int EW = 8;
    localparam logic [NR*DW-1:0] RV = 256'h66 << 24;
    localparam logic [NR*DW-1:0] WM = ~(256'hE4 << 32);
    localparam logic [NR-1:0]    PM = 32'h0000_0100;

    logic              LpcClock = 1'b0;
    logic              PciReset = 1'b1;
    logic [AW-1:0]     Addr     = '0;
    logic              Wr       = 1'b0;
    logic [DW-1:0]     DataWr   = '0;
    logic              Rd       = 1'b0;
    logic [DW-1:0]     RdData;
    logic              RdValid;
    logic [EW-1:0]     HwEvent  = '0;
    logic [NR*DW-1:0]  RegFlat;
    logic [NR-1:0]     WrStrobe;
    logic              Unlocked;
    logic              Irq;

    int total = 0;
    int bad   = 0;

    lpc_reg_bank #(
        .NUM_REGS   (NR),
        .AW         (AW),
        .DW         (DW),
        .RESET_VAL  (RV),
        .WR_MASK    (WM),
        .PROT_MASK  (PM),
        .EVT_W      (EW),
        .RELOCK_CYC (16)
    ) dut (
        .LpcClock (LpcClock),
        .PciReset (PciReset),
        .Addr     (Addr),
        .Wr       (Wr),
        .DataWr   (DataWr),
        .Rd       (Rd),
        .RdData   (RdData),
        .RdValid  (RdValid),
        .HwEvent  (HwEvent),
        .RegFlat  (RegFlat),
        .WrStrobe (WrStrobe),
        .Unlocked (Unlocked),
        .Irq      (Irq)
    );

    always #5 LpcClock = ~LpcClock;

    initial begin
        #500000;
        $display("FAIL timeout: sim did not finish, got running want done");
        $fatal(1);
    end

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        Addr = a; DataWr = d; Wr = 1'b1;
        @(posedge LpcClock); #1;
        Wr = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic v);
        Addr = a; Rd = 1'b1;
        @(posedge LpcClock); #1;
        Rd = 1'b0;
        d = RdData; v = RdValid;
    endtask

    task automatic tick();
        @(posedge LpcClock); #1;
    endtask

    task automatic test_reset();
        logic [DW-1:0] d; logic v;
        PciReset = 1'b1; Wr = 1'b1; Addr = 8'd3; DataWr = 8'hFF; Rd = 1'b1;
        tick(); tick();
        Wr = 1'b0; Rd = 1'b0;
        total++; if (RdValid !== 1'b0) begin bad++; $display("FAIL rst_rdvalid: got %b want 0", RdValid); end
        total++; if (RdData !== 8'h00) begin bad++; $display("FAIL rst_rddata: got %h want 00", RdData); end
        total++; if (Irq !== 1'b0) begin bad++; $display("FAIL rst_irq: got %b want 0", Irq); end
        total++; if (Unlocked !== 1'b0) begin bad++; $display("FAIL rst_unlocked: got %b want 0", Unlocked); end
        total++; if (WrStrobe !== 32'h0) begin bad++; $display("FAIL rst_strobe: got %h want 0", WrStrobe); end
        total++; if (RegFlat !== RV) begin bad++; $display("FAIL rst_regflat: got %h want %h", RegFlat, RV); end
        PciReset = 1'b0;
        rd(8'd3, d, v);
        total++; if (d !== 8'h66) begin bad++; $display("FAIL rst_read3: got %h want 66", d); end
        total++; if (v !== 1'b1) begin bad++; $display("FAIL rst_read3_valid: got %b want 1", v); end
        tick();
        total++; if (RdValid !== 1'b0) begin bad++; $display("FAIL rdvalid_pulse: got %b want 0", RdValid); end
    endtask

    task automatic test_wr_mask();
        logic [DW-1:0] d; logic v;
        wr(8'd4, 8'hFF);
        total++; if (WrStrobe !== 32'h0000_0010) begin bad++; $display("FAIL mask_strobe: got %h want 00000010", WrStrobe); end
        tick();
        total++; if (WrStrobe !== 32'h0) begin bad++; $display("FAIL mask_strobe_pulse: got %h want 0", WrStrobe); end
        rd(8'd4, d, v);
        total++; if (d !== 8'h1B) begin bad++; $display("FAIL mask_read4: got %h want 1b", d); end
        wr(8'd10, 8'hA5);
        rd(8'd10, d, v);
        total++; if (d !== 8'hA5) begin bad++; $display("FAIL full_read10: got %h want a5", d); end
        total++; if (RegFlat[87:80] !== 8'hA5) begin bad++; $display("FAIL flat10: got %h want a5", RegFlat[87:80]); end
    endtask

    task automatic test_protect();
        logic [DW-1:0] d; logic v;
        wr(8'd8, 8'h40);
        total++; if (WrStrobe !== 32'h0) begin bad++; $display("FAIL prot_locked_strobe: got %h want 0", WrStrobe); end
        rd(8'd8, d, v);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL prot_locked_val: got %h want 00", d); end
        wr(8'h1C, 8'h55);
        total++; if (WrStrobe !== 32'h1000_0000) begin bad++; $display("FAIL key_strobe: got %h want 10000000", WrStrobe); end
        rd(8'h1C, d, v);
        total++; if (d !== 8'h01) begin bad++; $display("FAIL key_state_key1: got %h want 01", d); end
        wr(8'h1C, 8'hAA);
        total++; if (Unlocked !== 1'b1) begin bad++; $display("FAIL unlock: got %b want 1", Unlocked); end
        rd(8'h1C, d, v);
        total++; if (d !== 8'h02) begin bad++; $display("FAIL key_state_unl: got %h want 02", d); end
        wr(8'd8, 8'h40);
        total++; if (WrStrobe !== 32'h0000_0100) begin bad++; $display("FAIL prot_unl_strobe: got %h want 00000100", WrStrobe); end
        rd(8'd8, d, v);
        total++; if (d !== 8'h40) begin bad++; $display("FAIL prot_unl_val: got %h want 40", d); end
        wr(8'h1C, 8'h00);
        total++; if (Unlocked !== 1'b0) begin bad++; $display("FAIL relock_key: got %b want 0", Unlocked); end
        rd(8'h1C, d, v);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL key_state_lock: got %h want 00", d); end
    endtask

    task automatic test_key_abort();
        logic [DW-1:0] d; logic v;
        wr(8'h1C, 8'h55);
        wr(8'd2, 8'h11);
        wr(8'h1C, 8'hAA);
        total++; if (Unlocked !== 1'b0) begin bad++; $display("FAIL abort_unlocked: got %b want 0", Unlocked); end
        rd(8'h1C, d, v);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL abort_state: got %h want 00", d); end
        rd(8'd2, d, v);
        total++; if (d !== 8'h11) begin bad++; $display("FAIL abort_reg2: got %h want 11", d); end
    endtask

    task automatic test_out_of_range();
        logic [DW-1:0] d; logic v;
        wr(8'h28, 8'h5A);
        total++; if (WrStrobe !== 32'h0) begin bad++; $display("FAIL oor_strobe: got %h want 0", WrStrobe); end
        rd(8'h28, d, v);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL oor_data: got %h want 00", d); end
        total++; if (v !== 1'b1) begin bad++; $display("FAIL oor_valid: got %b want 1", v); end
    endtask

    task automatic test_rd_wr_same();
        logic [DW-1:0] d; logic v;
        Addr = 8'd10; DataWr = 8'h3C; Wr = 1'b1; Rd = 1'b1;
        tick();
        Wr = 1'b0; Rd = 1'b0;
        total++; if (RdData !== 8'hA5) begin bad++; $display("FAIL rw_same_old: got %h want a5", RdData); end
        total++; if (WrStrobe !== 32'h0000_0400) begin bad++; $display("FAIL rw_same_strobe: got %h want 00000400", WrStrobe); end
        rd(8'd10, d, v);
        total++; if (d !== 8'h3C) begin bad++; $display("FAIL rw_same_new: got %h want 3c", d); end
    endtask

    task automatic test_status();
        logic [DW-1:0] d; logic v;
        wr(8'h1E, 8'h04);
        HwEvent = 8'h04;
        tick();
        HwEvent = 8'h00;
        total++; if (Irq !== 1'b0) begin bad++; $display("FAIL irq_latency: got %b want 0", Irq); end
        tick();
        total++; if (Irq !== 1'b1) begin bad++; $display("FAIL irq_set: got %b want 1", Irq); end
        rd(8'h1D, d, v);
        total++; if (d !== 8'h04) begin bad++; $display("FAIL stat_set: got %h want 04", d); end
        HwEvent = 8'h04;
        wr(8'h1D, 8'h04);
        HwEvent = 8'h00;
        total++; if (WrStrobe !== 32'h2000_0000) begin bad++; $display("FAIL w1c_strobe: got %h want 20000000", WrStrobe); end
        rd(8'h1D, d, v);
        total++; if (d !== 8'h04) begin bad++; $display("FAIL hw_wins: got %h want 04", d); end
        wr(8'h1D, 8'h04);
        total++; if (Irq !== 1'b1) begin bad++; $display("FAIL irq_hold: got %b want 1", Irq); end
        tick();
        total++; if (Irq !== 1'b0) begin bad++; $display("FAIL irq_clear: got %b want 0", Irq); end
        rd(8'h1D, d, v);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL w1c_clear: got %h want 00", d); end
        HwEvent = 8'h10;
        tick();
        HwEvent = 8'h00;
        tick(); tick();
        total++; if (Irq !== 1'b0) begin bad++; $display("FAIL irq_masked: got %b want 0", Irq); end
        rd(8'h1D, d, v);
        total++; if (d !== 8'h10) begin bad++; $display("FAIL stat_masked: got %h want 10", d); end
        wr(8'h1D, 8'hFF);
        rd(8'h1D, d, v);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL w1c_all: got %h want 00", d); end
    endtask

    task automatic test_relock();
        wr(8'h1C, 8'h55);
        wr(8'h1C, 8'hAA);
        total++; if (Unlocked !== 1'b1) begin bad++; $display("FAIL relock_unlock: got %b want 1", Unlocked); end
`ifdef LPC_REG_RELOCK_TIMEOUT_EN
        repeat (10) tick();
        wr(8'd10, 8'h3C);
        repeat (16) tick();
        total++; if (Unlocked !== 1'b1) begin bad++; $display("FAIL timeout_early: got %b want 1", Unlocked); end
        tick();
        total++; if (Unlocked !== 1'b0) begin bad++; $display("FAIL timeout_fire: got %b want 0", Unlocked); end
`else
        repeat (40) tick();
        total++; if (Unlocked !== 1'b1) begin bad++; $display("FAIL no_timeout: got %b want 1", Unlocked); end
        wr(8'h1C, 8'h00);
        total++; if (Unlocked !== 1'b0) begin bad++; $display("FAIL key_relock: got %b want 0", Unlocked); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d; logic v;
        wr(8'h1C, 8'h55);
        rd(8'h1C, d, v);
        total++; if (d !== 8'h01) begin bad++; $display("FAIL mid_key1: got %h want 01", d); end
        PciReset = 1'b1; Addr = 8'd10; DataWr = 8'h77; Wr = 1'b1;
        tick();
        Wr = 1'b0;
        total++; if (RegFlat !== RV) begin bad++; $display("FAIL mid_regflat: got %h want %h", RegFlat, RV); end
        total++; if (WrStrobe !== 32'h0) begin bad++; $display("FAIL mid_strobe: got %h want 0", WrStrobe); end
        PciReset = 1'b0;
        rd(8'h1C, d, v);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL mid_locked: got %h want 00", d); end
        rd(8'd10, d, v);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL mid_reg10: got %h want 00", d); end
        rd(8'd3, d, v);
        total++; if (d !== 8'h66) begin bad++; $display("FAIL mid_reg3: got %h want 66", d); end
    endtask

    initial begin
        test_reset();
        test_wr_mask();
        test_protect();
        test_key_abort();
        test_out_of_range();
        test_rd_wr_same();
        test_status();
        test_relock();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
